img_filter3x3_stream: RTL and testbench
=======================================

# img_filter3x3_stream

Streaming 3×3 neighbourhood filter for 8-bit grayscale frames. It sits after the RGB-to-gray stage and replaces per-pixel window assembly in software. Pixels arrive in raster order over a valid/ready handshake. Two internal line buffers build each 3×3 window with border padding. One of four kernels, selected per frame, is applied and the result streams out with backpressure.

## Interface
- `DW`, 8, pixel width in bits
- `IMG_W`, 300, frame width in pixels (≥3)
- `IMG_H`, 400, frame height in pixels (≥3)
- `PAD`, 100, constant value substituted for out-of-frame window taps
- `clk` input 1: single clock, rising edge
- `rst_n` input 1: reset, asynchronous and active-low
- `mode` input 2: kernel select; 0 pass, 1 Gaussian, 2 sharpen, 3 Sobel
- `in_valid` input 1: `in_data` is valid
- `in_ready` output 1: block accepts `in_data` this cycle
- `in_data` input DW: grayscale pixel, raster order
- `out_valid` output 1: `out_data` is valid
- `out_ready` input 1: sink accepts `out_data`
- `out_data` output DW: filtered pixel
- `out_last` output 1: marks the final pixel of a frame, qualified by `out_valid`
- `busy` output 1: a frame is in progress

## Operation
- **Virtual grid.** Rows vr 0..IMG_H, columns vc 0..IMG_W.
  - Positions with vr<IMG_H and vc<IMG_W are real pixels taken from the input.
  - Column IMG_W and row IMG_H are internal pad ticks. `in_ready` is 0 during them.
- **Ticks.**
  - A tick is an accepted real pixel, or a pad tick.
  - Ticks advance vc, then vr.
  - Each tick shifts the column into the window and writes the line buffers.
- **Output rule.** A tick at (vr,vc) with vr≥1 and vc≥1 emits the output for centre (vr−1, vc−1). That gives exactly IMG_W·IMG_H outputs per frame.
- **Out-of-frame taps.** Any window tap outside the frame reads PAD.
- **States.**
  - IDLE: counters zero, `busy`=0.
  - ROW: real ticks.
  - PADC: single end-of-row pad tick.
  - PADR: the final virtual row, all pad ticks.
- **Transitions.**
  - IDLE→ROW on the first accepted pixel. `mode` is sampled on this tick and held for the whole frame.
  - ROW→PADC after vc=IMG_W−1.
  - PADC→ROW when vr<IMG_H−1; PADC→PADR otherwise.
  - PADR→IDLE after tick (IMG_H, IMG_W). That tick emits `out_last`=1.
- **Kernels.** Taps p0..p8 in raster order, centre p4.
  - Mode 0: p4.
  - Mode 1: (p0+2p1+p2+2p3+4p4+2p5+p6+2p7+p8)>>4. Computed in DW+4 bits, truncated.
  - Mode 2: 5p4−p1−p3−p5−p7, signed, clamped to [0, 2^DW−1].
  - Mode 3: |gx|+|gy| with gx=(p2+2p5+p8)−(p0+2p3+p6) and gy=(p6+2p7+p8)−(p0+2p1+p2). Each term is DW+3 bits signed; the sum saturates to 2^DW−1.
- **Reset.** Reset mid-frame discards the partial frame. Counters, state and output register all clear.

## Timing
- **Reset values.** `in_ready`=0, `out_valid`=0, `out_data`=0, `out_last`=0, `busy`=0. One cycle after reset release, `in_ready`=1.
- **Tick enable.** en = !out_valid || out_ready. A tick occurs only when en=1.
- **Input handshake.** `in_ready` = en && state∈{IDLE,ROW}.
- **Pad ticks.** A pad tick occurs every cycle in which en=1 in PADC or PADR. No input is needed.
- **Latency.** `out_data` is registered and appears the cycle after its producing tick, with `out_valid`=1. It holds stable until `out_ready`.
- **Throughput.** Full rate is one tick per cycle. Per frame that is (IMG_W+1)(IMG_H+1) cycles.
- **Handshake corners.**
  - `in_valid`=0 in ROW stalls counters and emits nothing.
  - A simultaneous output accept and new tick is allowed; the output register updates with no bubble.
- **Back-to-back frames.** A new frame can be accepted the cycle after the PADR→IDLE tick.

## Configuration
- `IMG_REPLICATE_BORDER_EN` defined: out-of-frame taps take the nearest in-frame pixel (edge replication). `PAD` is ignored.
- `IMG_REPLICATE_BORDER_EN` undefined: out-of-frame taps read constant `PAD`.

## Test plan
All scenarios use IMG_W=4, IMG_H=3, PAD=100 unless stated.
- Mode 0, ramp input 0..11, `out_ready`=1 → outputs 0..11 in order, `out_last` only on 11, 20 cycles per frame.
- Mode 1, all pixels 50 → corner (0,0) = (7·100+9·50)>>4 = 71; centre (1,1) = 50; edge (0,1) = (4·100+12·50)>>4 = 62.
- Mode 2, all 50 → corner = 0 (clamped from 5·50−200−100); (1,1) = 50. Mode 3, all 50 → (1,1) = 0, corner saturates to 255.
- Mode 1 with random `in_valid` and `out_ready` toggling → same 12 values as the unstalled run. `out_data` is stable while `out_valid`=1 and `out_ready`=0. No drops or duplicates.
- Reset pulsed after 5 accepted pixels, then a full frame in mode 0 → exactly 12 outputs, matching the new frame only. `mode` changed mid-frame has no effect until the next frame.
- With `IMG_REPLICATE_BORDER_EN`, mode 1, all 50 → every output = 50.

Source files
------------

// File: rtl/img_filter3x3_stream.sv
`default_nettype none
// img_filter3x3_stream: raster-order 3x3 filter (pass/Gaussian/sharpen/Sobel) built from two line buffers.
// Optional macro IMG_REPLICATE_BORDER_EN: edge replication instead of constant PAD for out-of-frame taps.
module img_filter3x3_stream #(
    parameter int DW    = 8,
    parameter int IMG_W = 300,
    parameter int IMG_H = 400,
    parameter int PAD   = 100
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [1:0]    mode,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    output logic          busy
);
    localparam int CW = $clog2(IMG_W + 1);
    localparam int RW = $clog2(IMG_H + 1);
    localparam int SW = DW + 4;
    localparam int GW = DW + 3;
    localparam logic [CW-1:0] VC_PAD  = CW'(IMG_W);
    localparam logic [CW-1:0] VC_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] VR_PAD  = RW'(IMG_H);
    localparam logic [RW-1:0] VR_LAST = RW'(IMG_H - 1);
    localparam logic [DW-1:0] PAD_V   = DW'(PAD);
    localparam logic [DW-1:0] MAXV    = '1;

    typedef enum logic [1:0] {S_IDLE, S_ROW, S_PADC, S_PADR} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] vc, vc_nxt;
    logic [RW-1:0] vr, vr_nxt;
    logic [1:0]    mode_q;
    logic          started;
    logic          en, pad_tick, tick, emit;
    logic [DW-1:0] pix, result;
    logic [DW-1:0] lb0 [IMG_W+1];
    logic [DW-1:0] lb1 [IMG_W+1];
    logic [DW-1:0] w1 [3];
    logic [DW-1:0] w2 [3];
    logic [DW-1:0] raw [9];
    logic [DW-1:0] tp [9];
    logic [SW-1:0] e [9];
    logic [2:0]    row_out, col_out;
    logic [SW-1:0] g_sum, sh, sb;
    logic [GW-1:0] gx, gy, ax, ay;

    assign en       = !out_valid || out_ready;
    assign in_ready = started && en && (state == S_IDLE || state == S_ROW);
    assign pad_tick = en && (state == S_PADC || state == S_PADR);
    assign tick     = (in_ready && in_valid) || pad_tick;
    assign pix      = pad_tick ? PAD_V : in_data;
    assign emit     = (vr != '0) && (vc != '0);
    assign busy     = (state != S_IDLE);

    always_comb begin
        state_nxt = state;
        vc_nxt    = vc;
        vr_nxt    = vr;
        if (tick) begin
            if (vc == VC_PAD) begin
                vc_nxt = '0;
                vr_nxt = (vr == VR_PAD) ? '0 : vr + 1'b1;
            end else begin
                vc_nxt = vc + 1'b1;
            end
            case (state)
                S_IDLE:  state_nxt = S_ROW;
                S_ROW:   if (vc == VC_LAST) state_nxt = S_PADC;
                S_PADC:  state_nxt = (vr < VR_LAST) ? S_ROW : S_PADR;
                S_PADR:  if (vc == VC_PAD) state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // Window columns: w1 = vc-2, w2 = vc-1, incoming column = vc; rows top to bottom are vr-2..vr.
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            raw[3*r]   = w1[r];
            raw[3*r+1] = w2[r];
        end
        raw[2] = lb1[vc];
        raw[5] = lb0[vc];
        raw[8] = pix;
        row_out = {vr == VR_PAD, 1'b0, vr == RW'(1)};
        col_out = {vc == VC_PAD, 1'b0, vc == CW'(1)};
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
`ifdef IMG_REPLICATE_BORDER_EN
                // Centre is always in-frame, so clamping an outside row/column lands on it.
                tp[3*r+c] = raw[3*(row_out[r] ? 1 : r) + (col_out[c] ? 1 : c)];
`else
                tp[3*r+c] = (row_out[r] || col_out[c]) ? PAD_V : raw[3*r+c];
`endif
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 9; i++) e[i] = SW'(tp[i]);
        g_sum = e[0] + (e[1] << 1) + e[2] + (e[3] << 1) + (e[4] << 2)
              + (e[5] << 1) + e[6] + (e[7] << 1) + e[8];
        sh    = (e[4] << 2) + e[4] - e[1] - e[3] - e[5] - e[7];
        gx    = GW'(e[2] + (e[5] << 1) + e[8]) - GW'(e[0] + (e[3] << 1) + e[6]);
        gy    = GW'(e[6] + (e[7] << 1) + e[8]) - GW'(e[0] + (e[1] << 1) + e[2]);
        ax    = gx[GW-1] ? -gx : gx;
        ay    = gy[GW-1] ? -gy : gy;
        sb    = SW'(ax) + SW'(ay);
        case (mode_q)
            2'd0:    result = tp[4];
            2'd1:    result = DW'(g_sum >> 4);
            2'd2:    result = sh[SW-1] ? '0 : ((|sh[SW-2:DW]) ? MAXV : sh[DW-1:0]);
            default: result = (|sb[SW-1:DW]) ? MAXV : sb[DW-1:0];
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            vc        <= '0;
            vr        <= '0;
            mode_q    <= '0;
            started   <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else begin
            started <= 1'b1;
            state   <= state_nxt;
            vc      <= vc_nxt;
            vr      <= vr_nxt;
            if (tick && state == S_IDLE) mode_q <= mode;
            if (en) begin
                out_valid <= tick && emit;
                if (tick && emit) begin
                    out_data <= result;
                    out_last <= (vr == VR_PAD) && (vc == VC_PAD);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (tick) begin
            lb0[vc] <= pix;
            lb1[vc] <= lb0[vc];
            for (int r = 0; r < 3; r++) w1[r] <= w2[r];
            w2[0] <= raw[2];
            w2[1] <= raw[5];
            w2[2] <= raw[8];
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_img_filter3x3_stream.sv
`default_nettype none
// tb_img_filter3x3_stream: table-driven frames on a 4x3 image plus stall, reset and mode-change sequences.
module tb_img_filter3x3_stream;
    localparam int DW = 8;
    localparam int N  = 12;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    mode;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          busy;

    img_filter3x3_stream #(.DW(DW), .IMG_W(4), .IMG_H(3), .PAD(100)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [1:0]        mode;
        logic              ramp;
        logic [7:0]        val;
        logic [N-1:0][7:0] exp;   // element N-1 is output 0
    } vec_t;

    vec_t tbl [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_frame(input string tag, input logic [1:0] m, input logic ramp,
                             input logic [7:0] val, input logic [N-1:0][7:0] exp,
                             input bit rin, input bit rout, input bit chg);
        int k, got, t, c0, c1;
        bit hold;
        logic [7:0] held;
        k = 0; got = 0; t = 0; c0 = 0; c1 = 0; hold = 0; held = '0;
        fork
            begin
                while (k < N && t < 1000) begin
                    @(negedge clk);
                    in_valid = rin ? ($urandom_range(0, 2) != 0) : 1'b1;
                    in_data  = ramp ? 8'(k) : val;
                    if (k == 0) mode = m;
                    else if (chg) mode = ~m;
                    #1;
                    if (in_valid && in_ready) begin
                        if (k == 0) c0 = cyc;
                        k++;
                    end
                end
                @(negedge clk);
                in_valid = 1'b0;
            end
            begin
                while (got < N && t < 1000) begin
                    @(negedge clk);
                    out_ready = rout ? 1'($urandom_range(0, 1)) : 1'b1;
                    #1;
                    t++;
                    if (hold) begin
                        chk({tag, " hold valid"}, 32'(out_valid), 32'd1);
                        chk({tag, " hold data"}, 32'(out_data), 32'(held));
                    end
                    hold = 0;
                    if (out_valid) begin
                        if (out_ready) begin
                            chk($sformatf("%s data[%0d]", tag, got), 32'(out_data), 32'(exp[N-1-got]));
                            chk($sformatf("%s last[%0d]", tag, got), 32'(out_last), 32'(got == N-1));
                            if (got == N-1) begin
                                c1 = cyc;
                                if (!rout) chk({tag, " b2b in_ready"}, 32'(in_ready), 32'd1);
                            end
                            got++;
                        end else begin
                            hold = 1;
                            held = out_data;
                        end
                    end
                end
                if (got < N) chk({tag, " output count (timeout)"}, 32'(got), 32'(N));
            end
        join
        if (!rin && !rout) chk({tag, " frame cycles"}, 32'(c1 - c0), 32'd20);
        @(negedge clk);
        #1;
        chk({tag, " no extra output"}, 32'(out_valid), 32'd0);
        chk({tag, " idle busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; mode = 2'd0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;

        tbl[0] = '{mode: 2'd0, ramp: 1'b1, val: 8'd0,
                   exp: {8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9, 8'd10, 8'd11}};
`ifdef IMG_REPLICATE_BORDER_EN
        tbl[1] = '{mode: 2'd1, ramp: 1'b0, val: 8'd50, exp: {N{8'd50}}};
        tbl[2] = '{mode: 2'd2, ramp: 1'b0, val: 8'd50, exp: {N{8'd50}}};
        tbl[3] = '{mode: 2'd3, ramp: 1'b0, val: 8'd50, exp: {N{8'd0}}};
`else
        tbl[1] = '{mode: 2'd1, ramp: 1'b0, val: 8'd50,
                   exp: {8'd71, 8'd62, 8'd62, 8'd71, 8'd62, 8'd50, 8'd50, 8'd62, 8'd71, 8'd62, 8'd62, 8'd71}};
        tbl[2] = '{mode: 2'd2, ramp: 1'b0, val: 8'd50,
                   exp: {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd50, 8'd50, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}};
        tbl[3] = '{mode: 2'd3, ramp: 1'b0, val: 8'd50,
                   exp: {8'd255, 8'd200, 8'd200, 8'd255, 8'd200, 8'd0, 8'd0, 8'd200, 8'd255, 8'd200, 8'd200, 8'd255}};
`endif

        repeat (3) @(negedge clk);
        #1;
        chk("reset in_ready", 32'(in_ready), 32'd0);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset out_data", 32'(out_data), 32'd0);
        chk("reset out_last", 32'(out_last), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("release in_ready early", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("release in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 4; i++)
            run_frame($sformatf("vec%0d", i), tbl[i].mode, tbl[i].ramp, tbl[i].val, tbl[i].exp, 0, 0, 0);

        run_frame("stall", tbl[1].mode, tbl[1].ramp, tbl[1].val, tbl[1].exp, 1, 1, 0);

        // Abort a frame after 5 accepted pixels with an asynchronous reset.
        begin
            int acc;
            acc = 0;
            mode = 2'd2;
            out_ready = 1'b1;
            while (acc < 5 && cyc < 100000) begin
                @(negedge clk);
                in_valid = 1'b1;
                in_data  = 8'(200 + acc);
                #1;
                if (in_ready) acc++;
            end
            @(negedge clk);
            in_valid = 1'b0;
            rst_n = 1'b0;
            #1;
            chk("midreset busy", 32'(busy), 32'd0);
            chk("midreset out_valid", 32'(out_valid), 32'd0);
            chk("midreset in_ready", 32'(in_ready), 32'd0);
            @(negedge clk);
            rst_n = 1'b1;
            @(posedge clk);
            #1;
            chk("post-reset in_ready", 32'(in_ready), 32'd1);
        end

        run_frame("after-reset modechg", 2'd0, 1'b1, 8'd0, tbl[0].exp, 0, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
